rs_issue_sched: RTL and testbench

- Issue scheduler for the reservation station: picks which ready RS entry is sent to the ALU each cycle and drives the station's front/front_pos pair.
- Tracks relative entry age with an age matrix updated on every station push, so the oldest ready instruction issues first.
- Respects ALU back-pressure and the global ready/clear controls.
- Sits between the station's per-entry ready vector and its front port.

---
 rtl/rs_issue_sched.sv | 129 ++++++++++++
 tb/tb_rs_issue_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: reservation-station issue scheduler.
// Picks the ready entry sent to the ALU each cycle and drives front/front_pos.
// Optional feature macro: RS_AGE_ORDER_EN (oldest-first via age matrix);
// when undefined the highest-index ready entry wins and alloc is ignored.
module rs_issue_sched #(
  parameter int RS_SIZ   = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready,
  input  logic                clear,
  input  logic                alloc,
  input  logic [RS_IDX_W-1:0] alloc_pos,
  input  logic [RS_SIZ-1:0]   ent_ready,
  input  logic                alu_ready,
  output logic                front,
  output logic [RS_IDX_W-1:0] front_pos,
  output logic [1:0]          sched_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  front_nxt;
  logic [RS_IDX_W-1:0]   pos_nxt;
  logic [RS_SIZ-1:0]     pend_mask;
  logic [RS_SIZ-1:0]     cand;
  logic [RS_SIZ-1:0]     win_vec;
  logic [RS_IDX_W-1:0]   winner;

  // The entry being popped still shows ready until the station frees it.
  always_comb begin
    pend_mask = '0;
    if (front) pend_mask[front_pos] = 1'b1;
    cand = ent_ready & ~pend_mask;
  end

`ifdef RS_AGE_ORDER_EN
  // age[i][j]=1: entry i is older than entry j
  logic [RS_SIZ-1:0][RS_SIZ-1:0] age;

  // Age matrix: pushed entry becomes youngest; cleared on reset/flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      age <= '0;
    end else if (ready) begin
      if (clear) begin
        age <= '0;
      end else if (alloc) begin
        for (int i = 0; i < RS_SIZ; i++)
          for (int j = 0; j < RS_SIZ; j++)
            if (i == int'(alloc_pos))      age[i][j] <= 1'b0;
            else if (j == int'(alloc_pos)) age[i][j] <= 1'b1;
      end
    end
  end

  // A candidate wins when no other candidate is older than it.
  always_comb begin
    win_vec = '0;
    for (int i = 0; i < RS_SIZ; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < RS_SIZ; j++)
        older = older | (cand[j] & age[j][i]);
      win_vec[i] = cand[i] & ~older;
    end
  end
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc, alloc_pos};

  // Fixed priority: every candidate competes, highest index wins below.
  always_comb win_vec = cand;
`endif

  // Highest-index survivor; breaks ties left by a cleared/stale age matrix.
  always_comb begin
    winner = '0;
    for (int i = 0; i < RS_SIZ; i++)
      if (win_vec[i]) winner = RS_IDX_W'(i);
  end

  // Next-state and front generation; flush forces front low for one cycle.
  always_comb begin
    state_nxt = IDLE;
    front_nxt = 1'b0;
    pos_nxt   = front_pos;
    if (clear) begin
      state_nxt = FLUSH;
      pos_nxt   = '0;
    end else begin
      case (state)
        FLUSH: state_nxt = IDLE;
        default: begin
          if (cand != '0 && alu_ready) begin
            state_nxt = ISSUE;
            front_nxt = 1'b1;
            pos_nxt   = winner;
          end else if (cand != '0) begin
            state_nxt = STALL;
          end
        end
      endcase
    end
  end

  // State/front registers; everything holds while ready is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      front     <= 1'b0;
      front_pos <= '0;
    end else if (ready) begin
      state     <= state_nxt;
      front     <= front_nxt;
      front_pos <= pos_nxt;
    end
  end

  assign sched_state = state;

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: directed vectors with hand-computed expectations for
// rs_issue_sched, in both RS_AGE_ORDER_EN configurations.
module tb_rs_issue_sched;

  localparam int RS_SIZ   = 16;
  localparam int RS_IDX_W = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;

  logic                clk = 1'b0;
  logic                reset, ready, clear, alloc, alu_ready;
  logic [RS_IDX_W-1:0] alloc_pos;
  logic [RS_SIZ-1:0]   ent_ready;
  logic                front;
  logic [RS_IDX_W-1:0] front_pos;
  logic [1:0]          sched_state;

  int nvec = 0;
  int nerr = 0;

  rs_issue_sched #(.RS_SIZ(RS_SIZ), .RS_IDX_W(RS_IDX_W)) dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .alloc(alloc), .alloc_pos(alloc_pos), .ent_ready(ent_ready),
    .alu_ready(alu_ready), .front(front), .front_pos(front_pos),
    .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one cycle, sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expect an issue of entry exp this cycle, then retire it from ent_ready
  task automatic pop_chk(input string tag, input int exp);
    step();
    chk({tag, "_front"}, {31'd0, front}, 32'd1);
    chk({tag, "_pos"}, {28'd0, front_pos}, exp);
    ent_ready[exp] = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    step();
    chk({tag, "_front"}, {31'd0, front}, 32'd0);
    chk({tag, "_state"}, {30'd0, sched_state}, {30'd0, S_IDLE});
  endtask

  task automatic push(input int k);
    alloc = 1'b1;
    alloc_pos = RS_IDX_W'(k);
    step();
    alloc = 1'b0;
  endtask

  int ord[16];

  initial begin
    reset = 1'b0; ready = 1'b1; clear = 1'b0; alloc = 1'b0; alloc_pos = '0;
    ent_ready = 16'hFFFF; alu_ready = 1'b1;

    // reset dominates even with everything ready
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_front", {31'd0, front}, 32'd0);
      chk("rst_state", {30'd0, sched_state}, {30'd0, S_IDLE});
    end
    reset = 1'b1;
    // cleared matrix: tie resolves to highest index in both builds
    step();
    chk("rel_front", {31'd0, front}, 32'd1);
    chk("rel_pos", {28'd0, front_pos}, 32'd15);
    ent_ready = '0;
    idle_chk("rel_idle");

    // age ordering: alloc 5, 2, 9
    push(5); push(2); push(9);
    ent_ready = 16'h0224;
`ifdef RS_AGE_ORDER_EN
    pop_chk("age0", 5); pop_chk("age1", 2); pop_chk("age2", 9);
`else
    pop_chk("age0", 9); pop_chk("age1", 5); pop_chk("age2", 2);
`endif
    idle_chk("age_idle");

    // stall under ALU back-pressure
    ent_ready = 16'h0010; alu_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall_state", {30'd0, sched_state}, {30'd0, S_STALL});
      chk("stall_front", {31'd0, front}, 32'd0);
    end
    alu_ready = 1'b1;
    pop_chk("stall_rel", 4);
    idle_chk("stall_idle");

    // popped entry still shows ready: must not issue twice
    ent_ready = 16'h0008;
    step();
    chk("mask_front", {31'd0, front}, 32'd1);
    chk("mask_pos", {28'd0, front_pos}, 32'd3);
    step();
    chk("mask_nodup", {31'd0, front}, 32'd0);
    chk("mask_state", {30'd0, sched_state}, {30'd0, S_IDLE});
    ent_ready = '0;
    step();

    // make 0 older than 3, then flush must forget it
    push(0); push(3);
    ent_ready = 16'h00FF;
    step();
    chk("fl_pre_front", {31'd0, front}, 32'd1);
    chk("fl_pre_state", {30'd0, sched_state}, {30'd0, S_ISSUE});
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("fl_front", {31'd0, front}, 32'd0);
    chk("fl_state", {30'd0, sched_state}, {30'd0, S_FLUSH});
    idle_chk("fl_post");
    ent_ready = 16'h0009;
    pop_chk("fl_tie0", 3); pop_chk("fl_tie1", 0);
    idle_chk("fl_tie_idle");

    // ready low freezes an issue in progress
    ent_ready = 16'h0030;
    step();
    chk("frz_pre_pos", {28'd0, front_pos}, 32'd5);
    ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("frz_front", {31'd0, front}, 32'd1);
      chk("frz_pos", {28'd0, front_pos}, 32'd5);
      chk("frz_state", {30'd0, sched_state}, {30'd0, S_ISSUE});
    end
    ready = 1'b1;
    ent_ready[5] = 1'b0;
    pop_chk("frz_resume", 4);
    idle_chk("frz_idle");

    // new allocs after flush decide order
    push(1); push(6);
    ent_ready = 16'h0042;
`ifdef RS_AGE_ORDER_EN
    pop_chk("new0", 1); pop_chk("new1", 6);
`else
    pop_chk("new0", 6); pop_chk("new1", 1);
`endif
    idle_chk("new_idle");

    // full station: strict alloc order, one per cycle
    for (int i = 0; i < 16; i++) begin
      ord[i] = (i * 7) % 16;
      push(ord[i]);
    end
    ent_ready = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
`ifdef RS_AGE_ORDER_EN
      pop_chk("full", ord[i]);
`else
      pop_chk("full", 15 - i);
`endif
    end
    idle_chk("full_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
